hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16, meaning consecutive not-ready memory cycles before the error trap (legal 2..255).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 The block SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-006 The block SHALL have ports ex_mem_read  input  1  EX instruction is a load; ex_rd  input  5  its destination.
REQ-007 The block SHALL have port branch_taken_ex  input  1  redirect resolved in EX.
REQ-008 The block SHALL have ports mem_req  input  1  MEM stage accessing data memory; mem_ready  input  1  access completes this cycle.
REQ-009 The block SHALL have port pc_stall  output  1  hold PC.
REQ-010 The block SHALL have ports if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush  output  1 each  stall/flush for each pipeline register (a register ignores flush while stalled).
REQ-011 The block SHALL have port mem_error  output  1  sticky memory-timeout trap.
REQ-012 The block SHALL have ports stall_cycles, flush_events  output  32 each  performance counters.

Function
REQ-013 The block SHALL implement FSM states RUN, MEM_WAIT, ERR; reset state RUN.
REQ-014 mem_hold SHALL be defined as mem_req & !mem_ready, valid in RUN and MEM_WAIT.
REQ-015 load_use SHALL be ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-016 Priority SHALL be: ERR > mem_hold > branch_taken_ex > load_use > none; exactly one action per cycle.
REQ-017 On mem_hold: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_stall=0, mem_wb_flush=1 (bubble into WB); all other flushes 0.
REQ-018 On branch_taken_ex (no mem_hold): if_id_flush=id_ex_flush=1, all stalls 0; branch held during mem_hold SHALL be acted on in the first cycle mem_hold is low.
REQ-019 On load_use (no higher event): pc_stall=if_id_stall=1, id_ex_flush=1, others 0; one bubble per cycle the condition holds.
REQ-020 With no event all stall and flush outputs SHALL be 0.
REQ-021 RUN->MEM_WAIT when mem_hold; wait_cnt loads 1.
REQ-022 MEM_WAIT: mem_ready=1 -> RUN (release in that same cycle, no stall); mem_req=0 -> RUN (abort); else wait_cnt increments.
REQ-023 MEM_WAIT->ERR when mem_hold and wait_cnt==MAX_WAIT-1, i.e. after MAX_WAIT consecutive not-ready cycles.
REQ-024 ERR: all five stalls=1, all flushes=0, mem_error=1; exit only by reset.
REQ-025 stall_cycles SHALL increment each cycle pc_stall=1; flush_events each cycle any flush output=1; both wrap at 2^32-1 -> 0.

Reset
REQ-026 While reset=1 all stall outputs SHALL be 0, all flush outputs 1, mem_error 0.
REQ-027 On the edge with reset=1, state SHALL become RUN and wait_cnt, stall_cycles, flush_events 0, including mid-MEM_WAIT or in ERR.

Configuration
REQ-028 With HAZ_PERF_CNT_EN defined, stall_cycles and flush_events SHALL count per REQ-025.
REQ-029 Without HAZ_PERF_CNT_EN the ports SHALL remain and read constant 0, counter logic absent; all other behaviour identical.

Verification
REQ-030 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle; ex_rd=0 same stimulus -> no stall.
REQ-031 mem_req=1, mem_ready=0 for 3 cycles then 1 -> stalls high 3 cycles, mem_wb_flush=1 3 cycles, state RUN after 4th, stall_cycles=3.
REQ-032 branch_taken_ex=1 together with mem_hold for 2 cycles -> mem_hold response 2 cycles, then if_id_flush=id_ex_flush=1 in cycle 3.
REQ-033 MAX_WAIT=4, mem_ready held 0 -> ERR entered after 4th not-ready cycle, mem_error=1 and all stalls 1 until reset.
REQ-034 reset asserted during MEM_WAIT (cycle 2) -> next cycle RUN, counters 0, no stall.
REQ-035 Build without HAZ_PERF_CNT_EN, repeat REQ-031 -> stall_cycles=flush_events=0, control outputs unchanged.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Central stall/flush controller for a five-stage in-order pipeline.
// Resolves, in priority order, the memory-timeout trap, data-memory wait
// states, taken branches resolved in EX and load-use hazards, and produces
// one stall/flush action per cycle for every pipeline register.
//
// Build option: define HAZ_PERF_CNT_EN to include the stall_cycles /
// flush_events performance counters. Without it both ports read 0.
//
// Stall and flush outputs are combinational: a hazard must be answered in
// the same cycle it is detected.
module hazard_control_unit #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken_ex,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        mem_wb_stall,
    output logic        mem_wb_flush,
    output logic        mem_error,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    // Value of wait_cnt on the last tolerated not-ready cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 32'd1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    logic       mem_hold_s;
    logic       load_use_s;
    logic       rs1_hit_s;
    logic       rs2_hit_s;

    assign mem_hold_s = mem_req & ~mem_ready;
    assign rs1_hit_s  = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit_s  = id_uses_rs2 & (id_rs2 == ex_rd);
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use_s = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);

    // Next-state and wait counter: count consecutive not-ready cycles, trap on timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_hold_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready || !mem_req) begin
                    // Completion or abort both release the pipeline this cycle.
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_ERR;
                    wait_cnt_d = wait_cnt_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                // Only reset leaves the trap.
                state_d    = ST_ERR;
                wait_cnt_d = wait_cnt_q;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Output decode: exactly one prioritised action per cycle.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_stall = 1'b0;
        mem_wb_flush = 1'b0;
        mem_error    = 1'b0;
        if (reset) begin
            // Hold every pipeline register empty while reset is applied.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (state_q)
                ST_ERR: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_stall = 1'b1;
                    mem_error    = 1'b1;
                end
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_hold_s) begin
                        // Freeze the front of the pipe, drain a bubble into WB.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                    end else if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_s) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_stall = 1'b0;
                    end
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;
    logic        any_flush_s;

    assign any_flush_s = if_id_flush | id_ex_flush | ex_mem_flush | mem_wb_flush;

    // Performance counters: stalled-PC cycles and cycles with any flush; wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_q + {31'd0, pc_stall};
            flush_events_q <= flush_events_q + {31'd0, any_flush_s};
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (MAX_WAIT = 4).
// Directed scenarios compare against literal action vectors; a randomized
// run compares against a cycle-level behavioural model.
module tb_hazard_control_unit;

    localparam int MW = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Action vectors: {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f, err}
    localparam logic [9:0] V_NONE  = 10'b0_00_00_00_00_0;
    localparam logic [9:0] V_RESET = 10'b0_01_01_01_01_0;
    localparam logic [9:0] V_HOLD  = 10'b1_10_10_10_01_0;
    localparam logic [9:0] V_BR    = 10'b0_01_01_00_00_0;
    localparam logic [9:0] V_LU    = 10'b1_10_01_00_00_0;
    localparam logic [9:0] V_ERR   = 10'b1_10_10_10_10_1;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic        branch_taken_ex, mem_req, mem_ready;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_error;
    logic [31:0] stall_cycles, flush_events;
    logic [9:0]  ctl;

    int checks = 0;
    int errors = 0;

    // model state
    int          m_wait;
    bit          m_trap;
    logic [31:0] m_sc, m_fc;
    logic [9:0]  exp_ctl;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                  ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_error};

    hazard_control_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
        .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected action for the current inputs, straight from the priority rules.
    function automatic logic [9:0] model_ctl();
        bit hold, lu;
        hold = mem_req && !mem_ready;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (reset)           return V_RESET;
        if (m_trap)          return V_ERR;
        if (hold)            return V_HOLD;
        if (branch_taken_ex) return V_BR;
        if (lu)              return V_LU;
        return V_NONE;
    endfunction

    // Advance the model by one clock edge.
    task automatic model_commit(input logic [9:0] act);
        if (reset) begin
            m_wait = 0; m_trap = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
        end else begin
            if (PERF) begin
                if (act[9]) m_sc = m_sc + 32'd1;
                if (act[7] || act[5] || act[3] || act[1]) m_fc = m_fc + 32'd1;
            end
            if (!m_trap) begin
                if (mem_req && !mem_ready) begin
                    m_wait++;
                    if (m_wait == MW) m_trap = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1; mem_req = 1'b1; branch_taken_ex = 1'b1;
        settle();
        checks++;
        if (ctl !== V_RESET) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", ctl, V_RESET);
        end
        tick();
        settle();
        checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
        end
        tick();
        reset = 1'b0; clear_inputs();
        settle();
        checks++;
        if (ctl !== V_NONE) begin
            errors++; $display("FAIL idle_after_reset got=%b exp=%b", ctl, V_NONE);
        end
        tick();
    endtask

    task automatic test_load_use();
        // {read, ex_rd, rs1, rs2, use1, use2, expected}
        logic [9:0] exp_t [6];
        logic [21:0] stim [6];
        stim[0] = {1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0}; exp_t[0] = V_LU;
        stim[1] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1}; exp_t[1] = V_NONE;
        stim[2] = {1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1}; exp_t[2] = V_LU;
        stim[3] = {1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0}; exp_t[3] = V_NONE;
        stim[4] = {1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1}; exp_t[4] = V_NONE;
        stim[5] = {1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b1}; exp_t[5] = V_NONE;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            {ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2} = stim[i];
            settle();
            checks++;
            if (ctl !== exp_t[i]) begin
                errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, ctl, exp_t[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (ctl !== V_HOLD) begin
                errors++; $display("FAIL mem_wait_hold[%0d] got=%b exp=%b", i, ctl, V_HOLD);
            end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        checks++;
        if (ctl !== V_NONE) begin
            errors++; $display("FAIL mem_wait_release got=%b exp=%b", ctl, V_NONE);
        end
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        settle();
        checks++;
        if (stall_cycles !== (PERF ? 32'd3 : 32'd0) || flush_events !== (PERF ? 32'd3 : 32'd0)) begin
            errors++; $display("FAIL mem_wait_counters got=%0d/%0d exp=%0d/%0d",
                               stall_cycles, flush_events, PERF ? 3 : 0, PERF ? 3 : 0);
        end
        tick();
        // one not-ready cycle, then the request is withdrawn while a branch resolves
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0; branch_taken_ex = 1'b1;
        settle();
        checks++;
        if (ctl !== V_BR) begin
            errors++; $display("FAIL mem_abort_branch got=%b exp=%b", ctl, V_BR);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_hold();
        do_reset();
        branch_taken_ex = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        // load-use also present: must lose to both hold and branch
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (ctl !== V_HOLD) begin
                errors++; $display("FAIL branch_under_hold[%0d] got=%b exp=%b", i, ctl, V_HOLD);
            end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        checks++;
        if (ctl !== V_BR) begin
            errors++; $display("FAIL branch_after_hold got=%b exp=%b", ctl, V_BR);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_error();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < MW; i++) begin
            settle();
            checks++;
            if (ctl !== V_HOLD) begin
                errors++; $display("FAIL err_pre_hold[%0d] got=%b exp=%b", i, ctl, V_HOLD);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (ctl !== V_ERR) begin
                errors++; $display("FAIL err_trap[%0d] got=%b exp=%b", i, ctl, V_ERR);
            end
            tick();
            mem_ready = 1'b1; mem_req = 1'b0; branch_taken_ex = 1'b1;
        end
        settle();
        checks++;
        if (stall_cycles !== (PERF ? 32'd7 : 32'd0)) begin
            errors++; $display("FAIL err_stall_count got=%0d exp=%0d", stall_cycles, PERF ? 7 : 0);
        end
        reset = 1'b1;
        settle();
        checks++;
        if (ctl !== V_RESET) begin
            errors++; $display("FAIL err_reset got=%b exp=%b", ctl, V_RESET);
        end
        tick();
        reset = 1'b0; clear_inputs();
        settle();
        checks++;
        if (ctl !== V_NONE || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL err_cleared got=%b/%0d exp=%b/0", ctl, stall_cycles, V_NONE);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b1;
        settle();
        checks++;
        if (ctl !== V_NONE || stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            errors++; $display("FAIL reset_mid_wait got=%b/%0d/%0d exp=%b/0/0",
                               ctl, stall_cycles, flush_events, V_NONE);
        end
        tick();
        // wait count restarts: MW-1 not-ready cycles must not trap
        mem_ready = 1'b0;
        for (int i = 0; i < MW - 1; i++) tick();
        mem_ready = 1'b1;
        settle();
        checks++;
        if (ctl !== V_NONE) begin
            errors++; $display("FAIL no_trap_below_limit got=%b exp=%b", ctl, V_NONE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        m_wait = 0; m_trap = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 59) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = $urandom_range(0, 1) == 1;
            branch_taken_ex = ($urandom_range(0, 3) == 0);
            ex_mem_read     = $urandom_range(0, 1) == 1;
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = $urandom_range(0, 1) == 1;
            id_uses_rs2     = $urandom_range(0, 1) == 1;
            settle();
            exp_ctl = model_ctl();
            checks++;
            if (ctl !== exp_ctl || stall_cycles !== m_sc || flush_events !== m_fc) begin
                errors++;
                $display("FAIL random[%0d] got=%b/%0d/%0d exp=%b/%0d/%0d",
                         n, ctl, stall_cycles, flush_events, exp_ctl, m_sc, m_fc);
            end
            model_commit(exp_ctl);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_hold();
        test_error();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
